vector_mem_stream_master: RTL and testbench

- Initiator for the 128-bit vector data memory port: executes one strided burst command at a time.
- Load: reads words from vector memory and emits them on a valid/ready output stream.
- Store: accepts words from a valid/ready input stream and writes them to memory.
- Sits between the VPU load/store sequencer and the 512x128 vector RAM controller, whose read latency is 1 cycle and whose mem_ready pulse follows each mem_en.

---
 rtl/vector_mem_stream_master.sv | 250 +++++++++++++++++++++++++
 tb/tb_vector_mem_stream_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_stream_master.sv
// vector_mem_stream_master
// Initiator for the 128-bit vector data memory port. Runs one strided burst
// command at a time: loads read words from memory into a small buffer that
// feeds a valid/ready output stream; stores take words from a valid/ready
// input stream and write them to memory.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only while idle)
//   cmd_write/base/len/stride      burst description (len 0 = no access)
//   busy, done                     status; done pulses once per command
//   rd_data/rd_valid/rd_ready      load data stream (buffer head)
//   wr_data/wr_valid/wr_ready      store data stream
//   mem_en/we/addr/wdata           registered memory request
//   mem_rdata/mem_ready            memory response, one cycle after mem_en
module vector_mem_stream_master #(
  parameter int ADDR_W     = 9,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic              busy,
  output logic              done,
  output logic [127:0]      rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [127:0]      wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [127:0] ZERO_WORD = 128'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STORE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t            state_r;
  logic              cmd_ready_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] stride_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued_r;

  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [127:0]      mem_wdata_r;

  // An access that was on the bus last cycle and still owes a mem_ready.
  logic              wait_r;
  logic              wait_we_r;

  logic [127:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              more_s;
  logic [OCC_W-1:0]  occ_s;
  logic              wr_ready_s;
  logic              ld_issue_s;
  logic              st_issue_s;
  logic              issue_s;
  logic              resp_s;
  logic              push_s;
  logic              pop_s;
  logic              ld_complete_s;
  logic              st_complete_s;

  // Issue, response and completion decode from the current registers.
  always_comb begin
    more_s     = (issued_r < len_r);
    // Buffer slots already claimed: stored words, a read on the bus, and a
    // read waiting for its response. Counting all three keeps the buffer
    // from ever overflowing while still allowing one read per cycle.
    occ_s      = OCC_W'(count_r) + OCC_W'(mem_en_r) + OCC_W'(wait_r);
    ld_issue_s = (state_r == ST_LOAD) && more_s && (occ_s < OCC_W'(FIFO_DEPTH));
    wr_ready_s = (state_r == ST_STORE) && more_s;
    st_issue_s = wr_ready_s && wr_valid;
    issue_s    = ld_issue_s || st_issue_s;
    // Responses are only taken when an access is actually owed one.
    resp_s     = mem_ready && wait_r;
    push_s     = resp_s && !wait_we_r;
    pop_s      = rd_ready && (count_r != {CNT_W{1'b0}});
    // Finish in the cycle after the last beat leaves the buffer.
    ld_complete_s = !more_s && !mem_en_r && !wait_r &&
                    ((count_r == {CNT_W{1'b0}}) ||
                     ((count_r == CNT_W'(1)) && pop_s));
    // Finish in the cycle after the last write's mem_ready.
    st_complete_s = !more_s && !mem_en_r && (!wait_r || resp_s);
  end

  // Command FSM with its registered status outputs and burst bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cur_r       <= {ADDR_W{1'b0}};
      stride_r    <= {ADDR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      issued_r    <= {LEN_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_r       <= cmd_base;
            stride_r    <= cmd_stride;
            len_r       <= cmd_len;
            issued_r    <= {LEN_W{1'b0}};
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (cmd_len == {LEN_W{1'b0}}) begin
              state_r <= ST_FINISH;
              done_r  <= 1'b1;
            end else if (cmd_write) begin
              state_r <= ST_STORE;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (ld_issue_s) begin
            cur_r    <= cur_r + stride_r;
            issued_r <= issued_r + LEN_W'(1);
          end
          if (ld_complete_s) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end
        end
        ST_STORE: begin
          if (st_issue_s) begin
            cur_r    <= cur_r + stride_r;
            issued_r <= issued_r + LEN_W'(1);
          end
          if (st_complete_s) begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Registered memory request; strobes drop in any cycle without an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= ZERO_WORD;
    end else begin
      mem_en_r <= issue_s;
      mem_we_r <= st_issue_s;
      if (issue_s) begin
        mem_addr_r <= cur_r;
      end
      if (st_issue_s) begin
        mem_wdata_r <= wr_data;
      end
    end
  end

  // Track the access that owes a response so stray mem_ready is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_r    <= 1'b0;
      wait_we_r <= 1'b0;
    end else if (mem_en_r) begin
      wait_r    <= 1'b1;
      wait_we_r <= mem_we_r;
    end else if (resp_s) begin
      wait_r <= 1'b0;
    end
  end

  // Load data buffer: pushed by read responses, popped by the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= ZERO_WORD;
      end
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r] <= mem_rdata;
        wptr_r             <= wptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_data   = fifo_mem_r[rptr_r];
  assign rd_valid  = (count_r != {CNT_W{1'b0}});
  assign wr_ready  = wr_ready_s;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_vector_mem_stream_master.sv
// Bench for vector_mem_stream_master: table of burst commands with expected
// access counts/addresses, queue scoreboards for read addresses, load data
// and store writes, plus a hand-written mid-burst reset sequence.
module tb_vector_mem_stream_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [8:0]   cmd_base;
  logic [9:0]   cmd_len;
  logic [8:0]   cmd_stride;
  logic         busy;
  logic         done;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         mem_en;
  logic         mem_we;
  logic [8:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  vector_mem_stream_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: 512x128, read latency 1, mem_ready one cycle after mem_en.
  logic         preload;
  logic [127:0] ram [512];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) ram[i] <= 128'(i);
      mem_ready <= 1'b0;
      mem_rdata <= 128'd0;
    end else begin
      mem_ready <= mem_en;
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       write;
    logic [8:0] base;
    logic [9:0] len;
    logic [8:0] stride;
    int         stall;
    logic [7:0] pat;
    int         hold;
    int         exp_en;
    logic [8:0] exp_last;
    int         exp_busy;
    int         exp_span;
    int         exp_at_stall;
  } vec_t;

  typedef struct {
    logic [8:0]   a;
    logic [127:0] d;
  } wr_t;

  logic [127:0] ref_mem [512];
  logic [8:0]   exp_ra_q [$];
  logic [127:0] exp_rd_q [$];
  wr_t          exp_wr_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt, done_cnt, busy_cnt, en_at_stall;
  int first_rd_cyc, last_rd_cyc, last_pop_cyc, last_wr_cyc, done_cyc;
  int rd_stall_left, wr_idx;
  logic [7:0] wr_pat;
  logic       store_mode;
  logic [8:0] exp_wr_addr, wr_stride, last_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  // One cycle: sample at negedge, score bus/stream events, drive next inputs.
  task automatic step();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mem_en) begin
      en_cnt++;
      last_addr = mem_addr;
      if (mem_we) begin
        last_wr_cyc = cyc;
        if (exp_wr_q.size() == 0) fail("unexpected_write", 128'(mem_addr));
        else begin
          w = exp_wr_q.pop_front();
          check("wr_addr", 128'(mem_addr), 128'(w.a));
          check("wr_data", mem_wdata, w.d);
        end
      end else begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        last_rd_cyc = cyc;
        if (exp_ra_q.size() == 0) fail("unexpected_read", 128'(mem_addr));
        else check("rd_addr", 128'(mem_addr), 128'(exp_ra_q.pop_front()));
      end
    end
    if (rd_stall_left > 0) begin
      rd_ready = 1'b0;
      rd_stall_left--;
      if (rd_stall_left == 0) en_at_stall = en_cnt;
    end else begin
      rd_ready = 1'b1;
    end
    if (rd_valid && rd_ready) begin
      last_pop_cyc = cyc;
      if (exp_rd_q.size() == 0) fail("unexpected_beat", rd_data);
      else check("rd_data", rd_data, exp_rd_q.pop_front());
    end
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    if (store_mode) begin
      wr_valid = (wr_idx < 8) ? wr_pat[wr_idx] : 1'b1;
      wr_idx++;
      if (wr_valid && wr_ready) begin
        w.a = exp_wr_addr;
        w.d = wr_data;
        exp_wr_q.push_back(w);
        ref_mem[exp_wr_addr] = wr_data;
        exp_wr_addr = exp_wr_addr + wr_stride;
      end
    end else begin
      wr_valid = 1'b1;
    end
  endtask

  task automatic start_cmd(input vec_t v);
    logic [8:0] a;
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    en_cnt = 0; done_cnt = 0; busy_cnt = 0; en_at_stall = -1;
    first_rd_cyc = -1; last_rd_cyc = -1; last_pop_cyc = -1;
    last_wr_cyc = -1; done_cyc = -1;
    rd_stall_left = v.stall; wr_pat = v.pat; wr_idx = 0;
    exp_wr_addr = v.base; wr_stride = v.stride;
    if (!v.write) begin
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.base + 9'(i) * v.stride;
        exp_ra_q.push_back(a);
        exp_rd_q.push_back(ref_mem[a]);
      end
    end
    cmd_valid = 1'b1; cmd_write = v.write; cmd_base = v.base;
    cmd_len = v.len; cmd_stride = v.stride;
    store_mode = v.write;
  endtask

  task automatic run_cmd(input vec_t v);
    int c;
    int tail;
    start_cmd(v);
    c = 0;
    tail = -1;
    while (c < 600 && tail != 0) begin
      step();
      if (c >= v.hold) cmd_valid = 1'b0;
      else begin cmd_len = 10'd5; cmd_base = 9'h155; cmd_write = 1'b0; end
      if (tail > 0) tail--;
      else if (tail < 0 && done_cnt != 0) tail = 4;
      c++;
    end
    cmd_valid = 1'b0;
    store_mode = 1'b0;
    check("done_count", 128'(done_cnt), 128'(1));
    check("access_count", 128'(en_cnt), 128'(v.exp_en));
    if (v.exp_en != 0) check("last_addr", 128'(last_addr), 128'(v.exp_last));
    check("rd_addr_left", 128'(exp_ra_q.size()), 128'(0));
    check("rd_data_left", 128'(exp_rd_q.size()), 128'(0));
    check("wr_left", 128'(exp_wr_q.size()), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    if (v.exp_busy >= 0) check("busy_cycles", 128'(busy_cnt), 128'(v.exp_busy));
    if (v.exp_span >= 0) check("read_span", 128'(last_rd_cyc - first_rd_cyc), 128'(v.exp_span));
    if (v.exp_at_stall >= 0) check("reads_under_stall", 128'(en_at_stall), 128'(v.exp_at_stall));
    if (!v.write && v.len != 10'd0) check("done_after_pop", 128'(done_cyc - last_pop_cyc), 128'(1));
    if (v.write && v.len != 10'd0) check("done_after_wr", 128'(done_cyc - last_wr_cyc), 128'(2));
    exp_ra_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
    check({tag, "_wr_ready"}, 128'(wr_ready), 128'(0));
    check({tag, "_mem_en"}, 128'(mem_en), 128'(0));
    check({tag, "_mem_we"}, 128'(mem_we), 128'(0));
    check({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
    check({tag, "_mem_wdata"}, mem_wdata, 128'd0);
    check({tag, "_rd_data"}, rd_data, 128'd0);
  endtask

  vec_t vecs[9];
  vec_t v_rst;
  vec_t v_after;

  initial begin
    vecs[0] = '{1'b0, 9'h010, 10'd4, 9'h001, 0,  8'hFF, 0, 4, 9'h013, -1,  3, -1};
    vecs[1] = '{1'b0, 9'h000, 10'd8, 9'h001, 10, 8'hFF, 0, 8, 9'h007, -1, -1,  4};
    vecs[2] = '{1'b1, 9'h1FE, 10'd4, 9'h001, 0,  8'h2D, 0, 4, 9'h001, -1, -1, -1};
    vecs[3] = '{1'b1, 9'h100, 10'd4, 9'h080, 0,  8'hFF, 0, 4, 9'h080, -1, -1, -1};
    vecs[4] = '{1'b0, 9'h033, 10'd0, 9'h001, 0,  8'hFF, 1, 0, 9'h000,  1, -1, -1};
    vecs[5] = '{1'b0, 9'h1FE, 10'd4, 9'h001, 0,  8'hFF, 0, 4, 9'h001, -1,  3, -1};
    vecs[6] = '{1'b0, 9'h020, 10'd3, 9'h000, 0,  8'hFF, 0, 3, 9'h020, -1,  2, -1};
    vecs[7] = '{1'b1, 9'h0AA, 10'd0, 9'h003, 0,  8'hFF, 1, 0, 9'h000,  1, -1, -1};
    vecs[8] = '{1'b0, 9'h100, 10'd4, 9'h080, 0,  8'hFF, 0, 4, 9'h080, -1,  3, -1};
    v_rst   = '{1'b0, 9'h040, 10'd16, 9'h001, 0, 8'hFF, 0, 0, 9'h000, -1, -1, -1};
    v_after = '{1'b0, 9'h040, 10'd4, 9'h001, 0,  8'hFF, 0, 4, 9'h043, -1,  3, -1};

    for (int i = 0; i < 512; i++) ref_mem[i] = 128'(i);
    preload = 1'b1;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = 9'h000; cmd_len = 10'd0;
    cmd_stride = 9'h000; rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 128'd0;
    store_mode = 1'b0; rd_stall_left = 0; wr_idx = 0; wr_pat = 8'h00;
    en_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; last_pop_cyc = -1; last_wr_cyc = -1;
    repeat (3) step();
    preload = 1'b0;
    check_reset_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset two cycles into a 16-word load.
    start_cmd(v_rst);
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_reset_mem_en", 128'(mem_en), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_ra_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
    done_cnt = 0;
    repeat (3) step();
    check("no_done_in_reset", 128'(done_cnt), 128'(0));
    rst_n = 1'b1;
    step();
    check("no_done_after_reset", 128'(done_cnt), 128'(0));
    run_cmd(v_after);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
